// File: rtl/rast_tri_issue.sv
// Triangle issue queue feeding the rast input port: DEPTH-entry FIFO plus one output register.
// Optional build macro TRI_ISSUE_DEGEN_DROP_EN silently discards pushed triangles with coincident x/y vertices.
module rast_tri_issue #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int DEPTH  = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] in_tri_S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          in_color_U,
    input  logic                                          in_valid_H,
    output logic                                          in_ready_H,
    input  logic                                          flush_H,
    input  logic                                          halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U,
    output logic                                          validTri_R10H,
    output logic        [15:0]                            issued_cnt_U
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    if (RADIX >= SIGFIG) begin : g_radix_chk
        $error("RADIX must be smaller than SIGFIG");
    end

    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_mem   [DEPTH];
    logic        [COLORS-1:0][SIGFIG-1:0]          color_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    logic fifo_empty, push, keep, consume, or_load, pop, bypass, fifo_wr;

`ifdef TRI_ISSUE_DEGEN_DROP_EN
    function automatic logic tri_degen(input logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] t);
        logic d01, d12, d02;
        d01 = (t[0][0] == t[1][0]) && (t[0][1] == t[1][1]);
        d12 = (t[1][0] == t[2][0]) && (t[1][1] == t[2][1]);
        d02 = (t[0][0] == t[2][0]) && (t[0][1] == t[2][1]);
        return d01 | d12 | d02;
    endfunction
`endif

    assign fifo_empty = (count == '0);
    assign in_ready_H = (count != FULL_CNT) && !flush_H;
    assign push       = in_valid_H && in_ready_H;
`ifdef TRI_ISSUE_DEGEN_DROP_EN
    assign keep       = push && !tri_degen(in_tri_S);
`else
    assign keep       = push;
`endif
    assign consume    = validTri_R10H && halt_RnnnnL;
    // The output register refills whenever it is empty or being drained this edge.
    assign or_load    = (!validTri_R10H || consume) && !flush_H;
    assign pop        = or_load && !fifo_empty;
    assign bypass     = or_load && fifo_empty && keep;
    assign fifo_wr    = keep && !bypass;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            tri_mem[wr_ptr]   <= in_tri_S;
            color_mem[wr_ptr] <= in_color_U;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_H) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, fifo_wr} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validTri_R10H <= 1'b0;
            tri_R10S      <= '0;
            color_R10U    <= '0;
        end else if (flush_H) begin
            validTri_R10H <= 1'b0;
        end else if (or_load) begin
            validTri_R10H <= pop || bypass;
            if (pop) begin
                tri_R10S   <= tri_mem[rd_ptr];
                color_R10U <= color_mem[rd_ptr];
            end else if (bypass) begin
                tri_R10S   <= in_tri_S;
                color_R10U <= in_color_U;
            end
        end
    end

    // A consume coinciding with a flush still counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) issued_cnt_U <= '0;
        else if (consume) issued_cnt_U <= issued_cnt_U + 16'd1;
    end

endmodule
